// File: rtl/cpu_pkg.sv
// Shared processor definitions: sequencer states, branch encodings,
// instruction field positions and opcode constants.
package cpu_pkg;

    typedef enum logic [0:0] {
        Fetch = 1'b0,
        Issue = 1'b1
    } seq_state_e;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // BRANCH_CONTROL encodings; 2'b11 is reserved and behaves as BR_NONE.
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_NE   = 2'b10;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 24;
    localparam int unsigned DEST_MSB   = 23;
    localparam int unsigned DEST_LSB   = 16;
    localparam int unsigned OFF_MSB    = 23;
    localparam int unsigned OFF_LSB    = 16;
    localparam int unsigned SRC1_MSB   = 15;
    localparam int unsigned SRC1_LSB   = 8;
    localparam int unsigned SRC2_MSB   = 7;
    localparam int unsigned SRC2_LSB   = 0;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_BNE   = 8'h08;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch, issue and next-PC control bundle of pc_sequencer.
// STALL exists only when PC_SEQ_STALL_EN is defined.
interface pc_sequencer_if;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_BUSYWAIT;
    logic [31:0] IMEM_RDATA;
    logic [31:0] INSTRUCTION;
    logic        INSTR_VALID;
    logic [1:0]  BRANCH_CONTROL;
    logic        JUMP_CONTROL;
    logic        ZERO;
    logic [31:0] PC;
`ifdef PC_SEQ_STALL_EN
    logic        STALL;

    modport master (
        output IMEM_READ, IMEM_ADDR, INSTRUCTION, INSTR_VALID, PC,
        input  IMEM_BUSYWAIT, IMEM_RDATA, BRANCH_CONTROL, JUMP_CONTROL, ZERO, STALL
    );
    modport slave (
        input  IMEM_READ, IMEM_ADDR, INSTRUCTION, INSTR_VALID, PC,
        output IMEM_BUSYWAIT, IMEM_RDATA, BRANCH_CONTROL, JUMP_CONTROL, ZERO, STALL
    );
`else
    modport master (
        output IMEM_READ, IMEM_ADDR, INSTRUCTION, INSTR_VALID, PC,
        input  IMEM_BUSYWAIT, IMEM_RDATA, BRANCH_CONTROL, JUMP_CONTROL, ZERO
    );
    modport slave (
        input  IMEM_READ, IMEM_ADDR, INSTRUCTION, INSTR_VALID, PC,
        output IMEM_BUSYWAIT, IMEM_RDATA, BRANCH_CONTROL, JUMP_CONTROL, ZERO
    );
`endif
endinterface

// File: rtl/next_pc_calc.sv
// Next-PC selection: PC+4, or PC+4 plus a signed word offset when a jump or
// a satisfied branch is requested. All arithmetic wraps modulo 2^32.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [7:0]  off,
    input  logic [1:0]  branch_control,
    input  logic        jump_control,
    input  logic        zero,
    output logic [31:0] next_pc
);

    logic [31:0] pc4;
    logic [31:0] target;
    logic        taken;

    always_comb begin
        pc4    = pc + 32'd4;
        target = pc4 + {{22{off[7]}}, off, 2'b00};
        // Reserved encoding 2'b11 matches neither branch compare.
        taken  = jump_control
               | ((branch_control == BR_EQ) &  zero)
               | ((branch_control == BR_NE) & ~zero);
        next_pc = taken ? target : pc4;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch / PC sequencer: FETCH over a busywait handshake, ISSUE for one
// cycle, then load the next PC. PC_SEQ_STALL_EN adds STALL to extend ISSUE.
module pc_sequencer
    import cpu_pkg::*;
(
    input  logic          CLK,
    input  logic          RESET_N,
    pc_sequencer_if.master bus
);

    seq_state_e  state_q, state_d;
    logic        read_q, read_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] next_pc;
    logic        stall;

`ifdef PC_SEQ_STALL_EN
    assign stall = bus.STALL;
`else
    assign stall = 1'b0;
`endif

    next_pc_calc u_next_pc_calc (
        .pc             (pc_q),
        .off            (instr_q[OFF_MSB:OFF_LSB]),
        .branch_control (bus.BRANCH_CONTROL),
        .jump_control   (bus.JUMP_CONTROL),
        .zero           (bus.ZERO),
        .next_pc        (next_pc)
    );

    // read_q is registered so the request stays low until the first edge after reset.
    always_comb begin
        state_d = state_q;
        read_d  = read_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            Fetch: begin
                read_d = 1'b1;
                if (read_q && !bus.IMEM_BUSYWAIT) begin
                    instr_d = bus.IMEM_RDATA;
                    read_d  = 1'b0;
                    state_d = Issue;
                end
            end
            Issue: begin
                if (!stall) begin
                    pc_d    = next_pc;
                    read_d  = 1'b1;
                    state_d = Fetch;
                end
            end
            default: state_d = Fetch;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= Fetch;
            read_q  <= 1'b0;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign bus.IMEM_READ   = read_q;
    assign bus.IMEM_ADDR   = pc_q;
    assign bus.PC          = pc_q;
    assign bus.INSTRUCTION = instr_q;
    assign bus.INSTR_VALID = (state_q == Issue);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: scoreboarded fetch/issue steps, branch and
// jump cases, wrap-around, asynchronous reset, and STALL when PC_SEQ_STALL_EN is set.
module tb_pc_sequencer;
    import cpu_pkg::*;

    logic CLK;
    logic RESET_N;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [31:0] exp_pc;
    logic [63:0] exp_q[$];

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [7:0] off;
        off = (a == 32'hFFFF_FFFC) ? 8'h01 : 8'hFE;
        return {OP_ADD, off, a[15:8], a[7:0]};
    endfunction

    // Data only valid on an accepted read; garbage otherwise.
    always_comb begin
        bus.IMEM_RDATA = (bus.IMEM_READ && !bus.IMEM_BUSYWAIT) ? mem_word(bus.IMEM_ADDR)
                                                                 : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_instr(input int w, input logic [1:0] br, input logic jmp,
                            input logic z, input int stl, input logic [31:0] nxt);
        logic [63:0] e;
        exp_q.push_back({exp_pc, mem_word(exp_pc)});
        // Control inputs are noise outside the edge that ends ISSUE.
        bus.BRANCH_CONTROL = BR_EQ;
        bus.JUMP_CONTROL   = 1'b1;
        bus.ZERO           = 1'b1;
`ifdef PC_SEQ_STALL_EN
        bus.STALL = 1'b1;
`endif
        for (int i = 0; i < w; i++) begin
            bus.IMEM_BUSYWAIT = 1'b1;
            @(negedge CLK);
            check("busy_read", {31'b0, bus.IMEM_READ}, 32'd1);
            check("busy_addr", bus.IMEM_ADDR, exp_pc);
            check("busy_valid", {31'b0, bus.INSTR_VALID}, 32'd0);
        end
        bus.IMEM_BUSYWAIT = 1'b0;
        @(negedge CLK);
        check("issue_valid", {31'b0, bus.INSTR_VALID}, 32'd1);
        check("issue_read", {31'b0, bus.IMEM_READ}, 32'd0);
        if (bus.INSTR_VALID === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("issue_pc", bus.PC, e[63:32]);
            check("issue_instr", bus.INSTRUCTION, e[31:0]);
        end
`ifdef PC_SEQ_STALL_EN
        bus.STALL = (stl > 0);
        for (int i = 0; i < stl; i++) begin
            @(negedge CLK);
            check("stall_valid", {31'b0, bus.INSTR_VALID}, 32'd1);
            check("stall_pc", bus.PC, exp_pc);
            if (i == stl - 1) bus.STALL = 1'b0;
        end
`endif
        bus.BRANCH_CONTROL = br;
        bus.JUMP_CONTROL   = jmp;
        bus.ZERO           = z;
        @(negedge CLK);
        check("post_valid", {31'b0, bus.INSTR_VALID}, 32'd0);
        check("post_pc", bus.PC, nxt);
        check("post_read", {31'b0, bus.IMEM_READ}, 32'd1);
        check("post_addr", bus.IMEM_ADDR, nxt);
        exp_pc = nxt;
    endtask

    initial begin
        RESET_N            = 1'b0;
        bus.IMEM_BUSYWAIT  = 1'b0;
        bus.BRANCH_CONTROL = BR_NONE;
        bus.JUMP_CONTROL   = 1'b0;
        bus.ZERO           = 1'b0;
`ifdef PC_SEQ_STALL_EN
        bus.STALL = 1'b0;
`endif
        #1;
        check("rst_read", {31'b0, bus.IMEM_READ}, 32'd0);
        check("rst_valid", {31'b0, bus.INSTR_VALID}, 32'd0);
        check("rst_pc", bus.PC, 32'h0);
        check("rst_instr", bus.INSTRUCTION, 32'h0);
        @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        check("rel_read", {31'b0, bus.IMEM_READ}, 32'd0);
        @(negedge CLK);
        check("first_read", {31'b0, bus.IMEM_READ}, 32'd1);
        check("first_addr", bus.IMEM_ADDR, 32'h0);
        exp_pc = 32'h0;

        // Straight line, busywait at 8, reserved branch encoding at 0.
        do_instr(0, 2'b11, 1'b0, 1'b0, 0, 32'd4);
        do_instr(0, BR_NONE, 1'b0, 1'b0, 0, 32'd8);
        do_instr(3, BR_NONE, 1'b0, 1'b0, 0, 32'd12);
        do_instr(0, BR_NONE, 1'b0, 1'b1, 0, 32'd16);
        // beq / bne at 16 with off = -2.
        do_instr(0, BR_EQ, 1'b0, 1'b1, 0, 32'd12);
        do_instr(0, BR_NONE, 1'b0, 1'b0, 0, 32'd16);
        do_instr(0, BR_EQ, 1'b0, 1'b0, 0, 32'd20);
        do_instr(0, BR_NONE, 1'b1, 1'b0, 0, 32'd16);
        do_instr(1, BR_NE, 1'b0, 1'b1, 0, 32'd20);
        do_instr(0, BR_NONE, 1'b1, 1'b1, 0, 32'd16);
        do_instr(0, BR_NE, 1'b0, 1'b0, 0, 32'd12);
        // Walk back to 0 and jump to the top of memory.
        do_instr(0, BR_NONE, 1'b1, 1'b0, 0, 32'd8);
        do_instr(0, BR_NONE, 1'b1, 1'b0, 0, 32'd4);
        do_instr(0, BR_NONE, 1'b1, 1'b0, 0, 32'd0);
        do_instr(0, BR_NONE, 1'b1, 1'b0, 0, 32'hFFFF_FFFC);
        // Jump together with beq and ZERO=0 must still be taken.
        do_instr(0, BR_EQ, 1'b1, 1'b0, 0, 32'd4);
        do_instr(0, BR_NONE, 1'b1, 1'b0, 0, 32'd0);
        do_instr(2, BR_NONE, 1'b1, 1'b0, 0, 32'hFFFF_FFFC);
        do_instr(0, BR_NONE, 1'b0, 1'b0, 0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            do_instr(int'($urandom_range(0, 2)), BR_NONE, 1'b0, 1'b0, 0, 32'(4 * (i + 1)));
        end

        // Reset asserted mid-busywait at 40, between clock edges.
        bus.IMEM_BUSYWAIT = 1'b1;
        @(negedge CLK);
        check("mid_addr", bus.IMEM_ADDR, 32'd40);
        check("mid_read", {31'b0, bus.IMEM_READ}, 32'd1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("arst_read", {31'b0, bus.IMEM_READ}, 32'd0);
        check("arst_valid", {31'b0, bus.INSTR_VALID}, 32'd0);
        check("arst_pc", bus.PC, RESET_PC);
        bus.IMEM_BUSYWAIT = 1'b0;
        @(posedge CLK);
        #1;
        check("held_valid", {31'b0, bus.INSTR_VALID}, 32'd0);
        check("held_instr", bus.INSTRUCTION, 32'h0);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        check("restart_read", {31'b0, bus.IMEM_READ}, 32'd1);
        check("restart_addr", bus.IMEM_ADDR, RESET_PC);
        exp_pc = RESET_PC;
        do_instr(0, BR_NONE, 1'b0, 1'b0, 0, 32'd4);
        do_instr(1, BR_NONE, 1'b0, 1'b0, 2, 32'd8);

        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0d expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
